// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin arbiter sharing one DRAM port among NUM_REQ DMA requesters
// One transaction at a time; IDLE grants, BUSY waits for dramValid, DONE is a dead cycle before regrant.

module dram_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [32*NUM_REQ-1:0]   reqAddress,
  input  logic [32*NUM_REQ-1:0]   reqWriteData,
  input  logic [NUM_REQ-1:0]      reqReadEnable,
  input  logic [NUM_REQ-1:0]      reqWriteEnable,
  output logic [31:0]             reqReadData,
  output logic [NUM_REQ-1:0]      reqValid,
  output logic [31:0]             dramAddress,
  output logic [31:0]             dramWriteData,
  output logic                    dramReadEnable,
  output logic                    dramWriteEnable,
  input  logic [31:0]             dramReadData,
  input  logic                    dramValid,
  output logic                    busy,
  output logic [IDX_W-1:0]        grantId
);

  localparam int unsigned NUM_REQ_U = NUM_REQ;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             nextState;
  logic [IDX_W-1:0]   rrPtr;
  logic [NUM_REQ-1:0] pend;
  logic [IDX_W-1:0]   pickIdx;
  logic               pickValid;

  // Requester indices are always below NUM_REQ, so a single subtraction wraps.
  function automatic logic [IDX_W-1:0] wrapAdd(input logic [IDX_W-1:0] base,
                                               input int unsigned offset);
    int unsigned sum;
    sum = 32'(base) + offset;
    if (sum >= NUM_REQ_U) sum = sum - NUM_REQ_U;
    return sum[IDX_W-1:0];
  endfunction

  assign pend = reqReadEnable | reqWriteEnable;

  always_comb begin
    logic [IDX_W-1:0] cand;
    pickValid = 1'b0;
    pickIdx   = rrPtr;
    cand      = rrPtr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrapAdd(rrPtr, 32'(k));
      if (!pickValid && pend[cand]) begin
        pickValid = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (pickValid) nextState = BUSY;
      BUSY:    if (dramValid) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrPtr           <= '0;
      grantId         <= '0;
      dramAddress     <= '0;
      dramWriteData   <= '0;
      dramReadEnable  <= 1'b0;
      dramWriteEnable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pickValid) begin
            grantId         <= pickIdx;
            dramAddress     <= reqAddress[32*pickIdx +: 32];
            dramWriteData   <= reqWriteData[32*pickIdx +: 32];
            // A requester raising both enables is treated as a write.
            dramWriteEnable <= reqWriteEnable[pickIdx];
            dramReadEnable  <= reqReadEnable[pickIdx] & ~reqWriteEnable[pickIdx];
          end
        end
        BUSY: begin
          if (dramValid) begin
            dramReadEnable  <= 1'b0;
            dramWriteEnable <= 1'b0;
            rrPtr           <= wrapAdd(grantId, 32'd1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Completion is forwarded combinationally so the requester sees it in the DRAM's valid cycle.
  always_comb begin
    reqValid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqValid[i] = (state == BUSY) && dramValid && (grantId == IDX_W'(i));
    end
  end

  assign reqReadData = dramReadData;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed self-checking bench for dram_arbiter
// Fixed-latency scenarios; inputs change and outputs are sampled 1 ns after each rising edge.

module tb_dram_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [32*NUM_REQ-1:0] reqAddress;
  logic [32*NUM_REQ-1:0] reqWriteData;
  logic [NUM_REQ-1:0]    reqReadEnable;
  logic [NUM_REQ-1:0]    reqWriteEnable;
  logic [31:0]           reqReadData;
  logic [NUM_REQ-1:0]    reqValid;
  logic [31:0]           dramAddress;
  logic [31:0]           dramWriteData;
  logic                  dramReadEnable;
  logic                  dramWriteEnable;
  logic [31:0]           dramReadData;
  logic                  dramValid;
  logic                  busy;
  logic [IDX_W-1:0]      grantId;

  int passCnt = 0;
  int totalCnt = 0;

  dram_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .reqAddress(reqAddress), .reqWriteData(reqWriteData),
    .reqReadEnable(reqReadEnable), .reqWriteEnable(reqWriteEnable),
    .reqReadData(reqReadData), .reqValid(reqValid),
    .dramAddress(dramAddress), .dramWriteData(dramWriteData),
    .dramReadEnable(dramReadEnable), .dramWriteEnable(dramWriteEnable),
    .dramReadData(dramReadData), .dramValid(dramValid),
    .busy(busy), .grantId(grantId)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    reqAddress = '0; reqWriteData = '0;
    reqReadEnable = '0; reqWriteEnable = '0;
    dramReadData = '0; dramValid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) tick();
    totalCnt++; if (dramReadEnable !== 1'b0) $display("FAIL reset_rd got %b exp 0", dramReadEnable); else passCnt++;
    totalCnt++; if (dramWriteEnable !== 1'b0) $display("FAIL reset_wr got %b exp 0", dramWriteEnable); else passCnt++;
    totalCnt++; if (reqValid !== 4'b0000) $display("FAIL reset_valid got %b exp 0000", reqValid); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passCnt++;
    totalCnt++; if (grantId !== 2'd0) $display("FAIL reset_grant got %0d exp 0", grantId); else passCnt++;
  endtask

  task automatic test_single_read();
    reqAddress[32*1 +: 32] = 32'd24;
    reqReadEnable = 4'b0010;
    tick();
    totalCnt++; if (dramAddress !== 32'd24) $display("FAIL single_addr got %0d exp 24", dramAddress); else passCnt++;
    totalCnt++; if (dramReadEnable !== 1'b1) $display("FAIL single_rd got %b exp 1", dramReadEnable); else passCnt++;
    totalCnt++; if (grantId !== 2'd1) $display("FAIL single_grant got %0d exp 1", grantId); else passCnt++;
    repeat (3) tick();
    dramValid = 1'b1; dramReadData = 32'd1234;
    #1;
    totalCnt++; if (reqValid !== 4'b0010) $display("FAIL single_valid got %b exp 0010", reqValid); else passCnt++;
    totalCnt++; if (reqReadData !== 32'd1234) $display("FAIL single_data got %0d exp 1234", reqReadData); else passCnt++;
    tick();
    dramValid = 1'b0;
    totalCnt++; if (dramReadEnable !== 1'b0) $display("FAIL single_clear got %b exp 0", dramReadEnable); else passCnt++;
    totalCnt++; if (busy !== 1'b1) $display("FAIL single_done_busy got %b exp 1", busy); else passCnt++;
    tick();
    totalCnt++; if (dramReadEnable !== 1'b0) $display("FAIL single_no_regrant got %b exp 0", dramReadEnable); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("FAIL single_idle got %b exp 0", busy); else passCnt++;
    reqReadEnable = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    reset = 1'b0; #2; reset = 1'b1;
    tick();
    reqAddress = {32'h400, 32'h300, 32'h200, 32'h100};
    reqReadEnable = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      logic [31:0] expAddr;
      logic [3:0]  expValid;
      expAddr  = 32'h100 * (32'(order[n]) + 32'd1);
      expValid = 4'b0001 << order[n];
      tick();
      totalCnt++; if (grantId !== order[n]) $display("FAIL rr_grant%0d got %0d exp %0d", n, grantId, order[n]); else passCnt++;
      totalCnt++; if (dramAddress !== expAddr) $display("FAIL rr_addr%0d got %h exp %h", n, dramAddress, expAddr); else passCnt++;
      tick();
      dramValid = 1'b1; dramReadData = 32'h5000 + 32'(n);
      #1;
      totalCnt++; if (reqValid !== expValid) $display("FAIL rr_valid%0d got %b exp %b", n, reqValid, expValid); else passCnt++;
      tick();
      dramValid = 1'b0;
      if (n == 4) reqReadEnable = '0;
      tick();
    end
  endtask

  task automatic test_write_priority();
    reqAddress[32*2 +: 32] = 32'd12;
    reqWriteData[32*2 +: 32] = 32'habcd;
    reqReadEnable = 4'b0100; reqWriteEnable = 4'b0100;
    tick();
    totalCnt++; if (dramWriteEnable !== 1'b1) $display("FAIL wr_we got %b exp 1", dramWriteEnable); else passCnt++;
    totalCnt++; if (dramReadEnable !== 1'b0) $display("FAIL wr_re got %b exp 0", dramReadEnable); else passCnt++;
    totalCnt++; if (dramWriteData !== 32'habcd) $display("FAIL wr_data got %h exp abcd", dramWriteData); else passCnt++;
    totalCnt++; if (dramAddress !== 32'd12) $display("FAIL wr_addr got %0d exp 12", dramAddress); else passCnt++;
    tick();
    totalCnt++; if (reqValid !== 4'b0000) $display("FAIL wr_prevalid got %b exp 0000", reqValid); else passCnt++;
    dramValid = 1'b1;
    #1;
    totalCnt++; if (reqValid !== 4'b0100) $display("FAIL wr_valid got %b exp 0100", reqValid); else passCnt++;
    tick();
    dramValid = 1'b0;
    reqReadEnable = '0; reqWriteEnable = '0;
    totalCnt++; if (dramWriteEnable !== 1'b0) $display("FAIL wr_clear got %b exp 0", dramWriteEnable); else passCnt++;
    tick();
  endtask

  task automatic test_spurious_late();
    dramValid = 1'b1;
    #1;
    totalCnt++; if (reqValid !== 4'b0000) $display("FAIL spur_valid got %b exp 0000", reqValid); else passCnt++;
    tick();
    dramValid = 1'b0;
    totalCnt++; if (busy !== 1'b0) $display("FAIL spur_busy got %b exp 0", busy); else passCnt++;
    reqReadEnable = 4'b0001;
    tick();
    totalCnt++; if (grantId !== 2'd0) $display("FAIL late_g0 got %0d exp 0", grantId); else passCnt++;
    reqReadEnable = 4'b1001;
    tick();
    dramValid = 1'b1;
    tick();
    dramValid = 1'b0;
    reqReadEnable = 4'b1000;
    totalCnt++; if (dramReadEnable !== 1'b0) $display("FAIL late_done got %b exp 0", dramReadEnable); else passCnt++;
    tick();
    totalCnt++; if (busy !== 1'b0) $display("FAIL late_idle got %b exp 0", busy); else passCnt++;
    tick();
    totalCnt++; if (grantId !== 2'd3) $display("FAIL late_g3 got %0d exp 3", grantId); else passCnt++;
    totalCnt++; if (dramAddress !== 32'h400) $display("FAIL late_addr got %h exp 400", dramAddress); else passCnt++;
    totalCnt++; if (dramReadEnable !== 1'b1) $display("FAIL late_rd got %b exp 1", dramReadEnable); else passCnt++;
    dramValid = 1'b1;
    tick();
    dramValid = 1'b0;
    reqReadEnable = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    reqReadEnable = 4'b0010;
    tick();
    totalCnt++; if (grantId !== 2'd1) $display("FAIL mid_grant got %0d exp 1", grantId); else passCnt++;
    tick();
    #2;
    reset = 1'b0;
    #1;
    totalCnt++; if (dramReadEnable !== 1'b0) $display("FAIL mid_async_rd got %b exp 0", dramReadEnable); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy); else passCnt++;
    totalCnt++; if (grantId !== 2'd0) $display("FAIL mid_gid got %0d exp 0", grantId); else passCnt++;
    reqReadEnable = 4'b0011;
    #1;
    reset = 1'b1;
    tick();
    totalCnt++; if (grantId !== 2'd0) $display("FAIL mid_regrant got %0d exp 0", grantId); else passCnt++;
    totalCnt++; if (dramAddress !== 32'h100) $display("FAIL mid_addr got %h exp 100", dramAddress); else passCnt++;
    reqReadEnable = '0;
    dramValid = 1'b1;
    tick();
    dramValid = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_priority();
    test_spurious_late();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
